// File: rtl/trap_field.sv
// +--------------------------------------------------------------------------+
// | Module   : trap_field                                                    |
// | Purpose  : N_TRAPS patrolling trap blocks on the VGA scan, with an       |
// |            armed/disarmed phase cycle, pixel colour and robot hit flags. |
// | Options  : TRAP_FIELD_BLINK_EN - blink traps at the end of DISARMED.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module trap_field #(
    parameter int          COORD_W      = 9,
    parameter int          N_TRAPS      = 4,
    parameter int          TRAP_W       = 16,
    parameter int          TRAP_H       = 14,
    parameter int          X_MIN        = 75,
    parameter int          X_MAX        = 200,
    parameter int          Y_BASE       = 236,
    parameter int          Y_STEP       = 20,
    parameter int          STEP         = 1,
    parameter int          ARM_TICKS    = 60,
    parameter int          DISARM_TICKS = 30,
    parameter int          WARN_TICKS   = 8,
    parameter logic [2:0]  ARMED_COLOUR = 3'b100,
    parameter logic [2:0]  DIM_COLOUR   = 3'b001
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic [COORD_W-1:0] x_cord,
    input  logic [COORD_W-1:0] y_cord,
    input  logic [COORD_W-1:0] robot_x,
    input  logic [COORD_W-1:0] robot_y,
    input  logic               hit_clear,
    output logic [2:0]         flag,
    output logic               armed,
    output logic               hit,
    output logic               hit_latched
);

    localparam logic [0:0] c_ST_DISARMED = 1'b0;
    localparam logic [0:0] c_ST_ARMED    = 1'b1;

    localparam int c_CNT_MAX = (ARM_TICKS > DISARM_TICKS) ? ARM_TICKS : DISARM_TICKS;
    localparam int c_CNT_W   = (c_CNT_MAX > 2) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_WARN_START = DISARM_TICKS - WARN_TICKS;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [N_TRAPS-1:0]  w_pix_cov;
    logic [N_TRAPS-1:0]  w_bot_cov;
    logic                w_in_warn;
    logic                w_blink_hi;
    logic                w_hit;
    logic [2:0]          w_colour;
    logic [2:0]          r_flag;
    logic                r_hit;
    logic                r_hit_lat;

    // ------------------------------------------------------------------
    // Per-trap position, direction and footprint decode
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_TRAPS; gi++) begin : g_trap
            localparam logic [COORD_W-1:0] c_X_INIT = COORD_W'(X_MIN + 2 * gi * TRAP_W);
            localparam logic [COORD_W-1:0] c_YTOP   = COORD_W'(Y_BASE - gi * Y_STEP);
            localparam logic [COORD_W-1:0] c_YBOT   = COORD_W'(Y_BASE - gi * Y_STEP + TRAP_H - 1);
            localparam logic               c_DIR_INIT = ((gi % 2) == 0) ? 1'b1 : 1'b0;

            logic [COORD_W-1:0] r_xpos;
            logic               r_dir;
            logic [COORD_W-1:0] w_xright;
            logic [COORD_W:0]   w_reach;
            logic               w_at_right;
            logic               w_at_left;

            assign w_xright   = r_xpos + COORD_W'(TRAP_W - 1);
            // One extra bit so the look-ahead cannot wrap past the top of the coordinate range
            assign w_reach    = {1'b0, w_xright} + (COORD_W + 1)'(STEP);
            assign w_at_right = (w_reach > (COORD_W + 1)'(X_MAX));
            assign w_at_left  = ({1'b0, r_xpos} < (COORD_W + 1)'(X_MIN + STEP));

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_xpos <= c_X_INIT;
                    r_dir  <= c_DIR_INIT;
                end else if (frame_tick) begin
                    if (r_dir) begin
                        if (w_at_right) r_dir  <= 1'b0;
                        else            r_xpos <= r_xpos + COORD_W'(STEP);
                    end else begin
                        if (w_at_left)  r_dir  <= 1'b1;
                        else            r_xpos <= r_xpos - COORD_W'(STEP);
                    end
                end
            end

            assign w_pix_cov[gi] = (x_cord  >= r_xpos) && (x_cord  <= w_xright) &&
                                   (y_cord  >= c_YTOP) && (y_cord  <= c_YBOT);
            assign w_bot_cov[gi] = (robot_x >= r_xpos) && (robot_x <= w_xright) &&
                                   (robot_y >= c_YTOP) && (robot_y <= c_YBOT);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Armed / disarmed phase machine
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (frame_tick) begin
            if (r_state == c_ST_ARMED) begin
                if (r_cnt == c_CNT_W'(ARM_TICKS - 1)) begin
                    w_state_nxt = c_ST_DISARMED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end else begin
                if (r_cnt == c_CNT_W'(DISARM_TICKS - 1)) begin
                    w_state_nxt = c_ST_ARMED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_ARMED;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_in_warn = (r_state == c_ST_DISARMED) && (r_cnt >= c_CNT_W'(c_WARN_START));

`ifdef TRAP_FIELD_BLINK_EN
    logic r_blink;

    // Loads 1 on entry to the warning window so the first warning tick shows the armed colour
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_blink <= 1'b0;
        end else if (frame_tick) begin
            if ((w_state_nxt == c_ST_DISARMED) && (w_cnt_nxt == c_CNT_W'(c_WARN_START)))
                r_blink <= 1'b1;
            else
                r_blink <= ~r_blink;
        end
    end

    assign w_blink_hi = w_in_warn & r_blink;
`else
    assign w_blink_hi = w_in_warn & 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered pixel colour and hit detection
    // ------------------------------------------------------------------
    assign w_colour = ((r_state == c_ST_ARMED) || w_blink_hi) ? ARMED_COLOUR : DIM_COLOUR;
    assign w_hit    = (r_state == c_ST_ARMED) && (|w_bot_cov);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_flag    <= 3'b000;
            r_hit     <= 1'b0;
            r_hit_lat <= 1'b0;
        end else begin
            r_flag <= (|w_pix_cov) ? w_colour : 3'b000;
            r_hit  <= w_hit;
            if (w_hit)          r_hit_lat <= 1'b1;
            else if (hit_clear) r_hit_lat <= 1'b0;
        end
    end

    assign flag        = r_flag;
    assign armed       = r_state[0];
    assign hit         = r_hit;
    assign hit_latched = r_hit_lat;

endmodule

`default_nettype wire

// File: tb/tb_trap_field.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_trap_field                                                 |
// | Purpose  : Self-checking bench for trap_field against a frame-level model|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_trap_field;

    localparam int W    = 9;
    localparam int N    = 4;
    localparam int TW   = 16;
    localparam int TH   = 14;
    localparam int XMIN = 75;
    localparam int XMAX = 200;
    localparam int YB   = 236;
    localparam int YS   = 20;
    localparam int ST   = 1;
    localparam int AT   = 60;
    localparam int DT   = 30;
    localparam int WT   = 8;

    logic         clock = 1'b0;
    logic         resetn = 1'b1;
    logic         frame_tick = 1'b0;
    logic         hit_clear = 1'b0;
    logic [W-1:0] x_cord = '0;
    logic [W-1:0] y_cord = '0;
    logic [W-1:0] robot_x = '0;
    logic [W-1:0] robot_y = '0;
    logic [2:0]   flag;
    logic         armed;
    logic         hit;
    logic         hit_latched;

    trap_field #(
        .COORD_W(W), .N_TRAPS(N), .TRAP_W(TW), .TRAP_H(TH), .X_MIN(XMIN), .X_MAX(XMAX),
        .Y_BASE(YB), .Y_STEP(YS), .STEP(ST), .ARM_TICKS(AT), .DISARM_TICKS(DT),
        .WARN_TICKS(WT), .ARMED_COLOUR(3'b100), .DIM_COLOUR(3'b001)
    ) dut (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
        .x_cord(x_cord), .y_cord(y_cord), .robot_x(robot_x), .robot_y(robot_y),
        .hit_clear(hit_clear), .flag(flag), .armed(armed), .hit(hit),
        .hit_latched(hit_latched)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: trap positions, phase as (armed, ticks spent in phase), sticky hit
    int mx[N];
    bit mdir[N];
    bit marmed;
    int mcnt;
    bit mlat;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i]   = XMIN + 2 * i * TW;
            mdir[i] = (i % 2 == 0);
        end
        marmed = 1'b1;
        mcnt   = 0;
        mlat   = 1'b0;
    endtask

    task automatic model_tick();
        for (int i = 0; i < N; i++) begin
            if (mdir[i]) begin
                if (mx[i] + TW - 1 + ST > XMAX) mdir[i] = 1'b0;
                else                            mx[i]   = mx[i] + ST;
            end else begin
                if (mx[i] < XMIN + ST) mdir[i] = 1'b1;
                else                   mx[i]   = mx[i] - ST;
            end
        end
        mcnt++;
        if (marmed && mcnt == AT) begin
            marmed = 1'b0;
            mcnt   = 0;
        end else if (!marmed && mcnt == DT) begin
            marmed = 1'b1;
            mcnt   = 0;
        end
    endtask

    function automatic bit covers(input int x, input int y);
        bit c = 1'b0;
        for (int i = 0; i < N; i++)
            if (x >= mx[i] && x <= mx[i] + TW - 1 && y >= YB - i * YS && y <= YB - i * YS + TH - 1)
                c = 1'b1;
        return c;
    endfunction

    function automatic logic [2:0] colour();
        if (marmed) return 3'b100;
`ifdef TRAP_FIELD_BLINK_EN
        if (mcnt >= DT - WT && ((mcnt - (DT - WT)) % 2) == 0) return 3'b100;
`endif
        return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from pre-edge model state, then compare after the edge
    task automatic step(input bit tk, input int px, input int py, input int rx, input int ry,
                        input bit clr);
        logic [2:0] ef;
        bit eh, el;
        frame_tick = tk;
        x_cord     = W'(px);
        y_cord     = W'(py);
        robot_x    = W'(rx);
        robot_y    = W'(ry);
        hit_clear  = clr;
        ef = covers(px, py) ? colour() : 3'b000;
        eh = marmed && covers(rx, ry);
        el = eh | (mlat & ~clr);
        @(posedge clock);
        #1;
        mlat = el;
        if (tk) model_tick();
        chk("flag",        9'(flag),        9'(ef));
        chk("hit",         9'(hit),         9'(eh));
        chk("hit_latched", 9'(hit_latched), 9'(el));
        chk("armed",       9'(armed),       9'(marmed));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flag"},  9'(flag),        9'd0);
        chk({tag, "_armed"}, 9'(armed),       9'd1);
        chk({tag, "_hit"},   9'(hit),         9'd0);
        chk({tag, "_lat"},   9'(hit_latched), 9'd0);
    endtask

    initial begin
        model_reset();
        #1 resetn = 1'b0;
        #1 check_reset_outputs("por");
        @(posedge clock);
        #1 resetn = 1'b1;

        // Footprint corners of trap 0 right after reset
        step(0, 75, 236, 0, 0, 0);  chk("px_75_236", 9'(flag), 9'h4);
        step(0, 91, 236, 0, 0, 0);  chk("px_91_236", 9'(flag), 9'h0);
        step(0, 75, 250, 0, 0, 0);  chk("px_75_250", 9'(flag), 9'h0);
        step(0, 75, 249, 0, 0, 0);  chk("px_75_249", 9'(flag), 9'h4);
        step(0, 171, 176, 0, 0, 0); chk("px_trap3",  9'(flag), 9'h4);

        // Trap 0 sweep: probe its right edge on tick cycles, one past it afterwards
        for (int t = 0; t < 200; t++) begin
            step(1, mx[0] + TW - 1, YB + (t % TH), 0, 0, 0);
            step(0, mx[0] + TW, YB + 4, mx[0] + 3, YB + 5, 0);
            if (t % 7 == 0) step(0, mx[0] - 1, YB, 0, 0, 0);
        end

        // Hit path after a fresh reset
        resetn = 1'b0;
        model_reset();
        @(posedge clock);
        #1 resetn = 1'b1;
        step(0, 0, 0, 80, 240, 0);
        chk("hit_80_240", 9'(hit), 9'd1);
        for (int g = 0; g < 200 && marmed; g++) step(1, mx[0], YB, mx[0] + 2, 240, 0);
        step(0, mx[0], YB, mx[0] + 2, 240, 0);
        chk("disarmed_hit", 9'(hit), 9'd0);
        chk("disarmed_lat", 9'(hit_latched), 9'd1);
        step(0, 0, 0, mx[0] + 2, 240, 1);
        chk("lat_cleared", 9'(hit_latched), 9'd0);
        for (int g = 0; g < 200 && !marmed; g++) step(1, mx[0] + 1, YB + 1, mx[0] + 2, 240, 0);
        step(0, 0, 0, mx[0] + 2, 240, 1);
        chk("lat_clr_vs_hit", 9'(hit_latched), 9'd1);

        // Asynchronous reset mid-phase with traps displaced and the latch set
        for (int t = 0; t < 20; t++) step(1, mx[0], YB, mx[0], YB, 0);
        #2 resetn = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        @(posedge clock);
        #1 resetn = 1'b1;
        step(0, 75, 236, 0, 0, 0);  chk("post_rst_px", 9'(flag), 9'h4);
        step(1, 75, 236, 0, 0, 0);  chk("tick_old_pos", 9'(flag), 9'h4);
        step(0, 75, 236, 0, 0, 0);  chk("tick_new_pos", 9'(flag), 9'h0);

        // Randomised traffic biased toward the trap band
        for (int r = 0; r < 3000; r++) begin
            step(($urandom % 3) == 0,
                 int'($urandom_range(60, 215)), int'($urandom_range(160, 260)),
                 int'($urandom_range(60, 215)), int'($urandom_range(160, 260)),
                 ($urandom % 8) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
